// File: rtl/seq_pkg.sv
// Shared types for the motion sequencer.
//   seq_state_e : controller state, value doubles as the LEDG debug encoding
//   instr_t     : one queued instruction word as stored in the FIFO
//   DIR_*       : direction field codes
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_CLEAR = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [2:0] torque;
        logic [1:0] dir;
    } instr_t;

    localparam logic [1:0] DIR_FWD   = 2'd0;
    localparam logic [1:0] DIR_REV   = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

endpackage

// File: rtl/step_timer.sv
// Loadable dwell down-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload with TICKS_PER_STEP-1 (wins over en)
//   en         : count down by one; counter is frozen while low
//   zero       : counter currently at zero
module step_timer #(
    parameter int TICKS_PER_STEP = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = $clog2(TICKS_PER_STEP);
    localparam logic [W-1:0] LOAD_VAL = W'(TICKS_PER_STEP - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Instruction-queue robot controller: turns debounced key pulses into FIFO
// strobes and plays queued 5-bit instructions out as motor commands, each
// held for TICKS_PER_STEP cycles, with pause/resume and abort.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   save/execute/clear/delete_pulse  one-cycle key requests
//   fifo_empty/full     FIFO status
//   fifo_dout[4:0]      FIFO read data ({torque, dir}), valid cycle after fifo_re
//   fifo_we/re/del/rst  FIFO strobes, one cycle each
//   cmd_valid/dir/torque  active motor command
//   done                end of queue execution pulse
//   err                 rejected save (full) / execute (empty) pulse
//   step_count          instructions started this run, saturating
//   state_dbg           state encoding for the lamps
//
// state | meaning
// IDLE  | accept save/delete/execute/clear
// FETCH | fifo_re high, instruction word arrives next cycle
// LOAD  | latch instruction, start dwell timer
// RUN   | hold command while the dwell timer runs
// PAUSE | command withdrawn, dwell timer frozen
// CLEAR | fifo_rst high, command cleared
module motion_sequencer
    import seq_pkg::*;
#(
    parameter int TICKS_PER_STEP = 50_000_000,
    parameter int STEP_W         = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              save_pulse,
    input  logic              execute_pulse,
    input  logic              clear_pulse,
    input  logic              delete_pulse,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [4:0]        fifo_dout,
    output logic              fifo_we,
    output logic              fifo_re,
    output logic              fifo_del,
    output logic              fifo_rst,
    output logic              cmd_valid,
    output logic [1:0]        cmd_dir,
    output logic [2:0]        cmd_torque,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] step_count,
    output logic [2:0]        state_dbg
);

    seq_state_e        state_q,      state_d;
    logic              fifo_we_q,    fifo_we_d;
    logic              fifo_re_q,    fifo_re_d;
    logic              fifo_del_q,   fifo_del_d;
    logic              fifo_rst_q,   fifo_rst_d;
    logic              cmd_valid_q,  cmd_valid_d;
    logic [1:0]        cmd_dir_q,    cmd_dir_d;
    logic [2:0]        cmd_torque_q, cmd_torque_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;

    instr_t load_instr;
    logic   tmr_load;
    logic   tmr_en;
    logic   tmr_zero;

    assign load_instr = fifo_dout;

    // The timer only counts on cycles that stay in RUN, so the cycle in
    // which a pause is requested does not consume dwell time.
    assign tmr_load = (state_q == ST_LOAD);
    assign tmr_en   = (state_q == ST_RUN) && (state_d == ST_RUN);

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_step_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .en   (tmr_en),
        .zero (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        fifo_we_d    = 1'b0;
        fifo_re_d    = 1'b0;
        fifo_del_d   = 1'b0;
        fifo_rst_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cmd_valid_d  = cmd_valid_q;
        cmd_dir_d    = cmd_dir_q;
        cmd_torque_d = cmd_torque_q;
        step_count_d = step_count_q;

        if (clear_pulse && (state_q != ST_CLEAR)) begin
            // Abort has top priority in every active state.
            state_d      = ST_CLEAR;
            fifo_rst_d   = 1'b1;
            cmd_valid_d  = 1'b0;
            cmd_dir_d    = DIR_FWD;
            cmd_torque_d = '0;
            step_count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (execute_pulse) begin
                        if (fifo_empty) begin
                            err_d = 1'b1;
                        end else begin
                            step_count_d = '0;
                            fifo_re_d    = 1'b1;
                            state_d      = ST_FETCH;
                        end
                    end else if (save_pulse) begin
                        if (fifo_full) begin
                            err_d = 1'b1;
                        end else begin
                            fifo_we_d = 1'b1;
                        end
                    end else if (delete_pulse) begin
                        fifo_del_d = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    cmd_torque_d = load_instr.torque;
                    cmd_dir_d    = load_instr.dir;
                    cmd_valid_d  = 1'b1;
                    if (step_count_q != '1) begin
                        step_count_d = step_count_q + 1'b1;
                    end
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (execute_pulse) begin
                        cmd_valid_d = 1'b0;
                        state_d     = ST_PAUSE;
                    end else if (tmr_zero) begin
                        if (fifo_empty) begin
                            cmd_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            // Command fields hold through FETCH/LOAD so the
                            // displays never blank between instructions.
                            fifo_re_d = 1'b1;
                            state_d   = ST_FETCH;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (execute_pulse) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fifo_we_q    <= 1'b0;
            fifo_re_q    <= 1'b0;
            fifo_del_q   <= 1'b0;
            fifo_rst_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_dir_q    <= DIR_FWD;
            cmd_torque_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            fifo_we_q    <= fifo_we_d;
            fifo_re_q    <= fifo_re_d;
            fifo_del_q   <= fifo_del_d;
            fifo_rst_q   <= fifo_rst_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_dir_q    <= cmd_dir_d;
            cmd_torque_q <= cmd_torque_d;
            done_q       <= done_d;
            err_q        <= err_d;
            step_count_q <= step_count_d;
        end
    end

    assign fifo_we    = fifo_we_q;
    assign fifo_re    = fifo_re_q;
    assign fifo_del   = fifo_del_q;
    assign fifo_rst   = fifo_rst_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_dir    = cmd_dir_q;
    assign cmd_torque = cmd_torque_q;
    assign done       = done_q;
    assign err        = err_q;
    assign step_count = step_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_motion_sequencer.sv
module tb_motion_sequencer;
    import seq_pkg::*;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       save_pulse = 1'b0, execute_pulse = 1'b0, clear_pulse = 1'b0, delete_pulse = 1'b0;
    logic       fifo_empty, fifo_full;
    logic [4:0] fifo_dout = '0;
    logic       fifo_we, fifo_re, fifo_del, fifo_rst;
    logic       cmd_valid, done, err;
    logic [1:0] cmd_dir;
    logic [2:0] cmd_torque;
    logic [4:0] step_count;
    logic [2:0] state_dbg;
    logic [4:0] sw = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    motion_sequencer #(.TICKS_PER_STEP(TICKS), .STEP_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .save_pulse(save_pulse), .execute_pulse(execute_pulse),
        .clear_pulse(clear_pulse), .delete_pulse(delete_pulse),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_del(fifo_del), .fifo_rst(fifo_rst),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_torque(cmd_torque),
        .done(done), .err(err), .step_count(step_count), .state_dbg(state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- 8-deep FIFO model ----------------
    logic [4:0] fmem [0:7];
    logic [2:0] fwp = '0, frp = '0;
    logic [3:0] fcnt = '0;
    assign fifo_empty = (fcnt == 4'd0);
    assign fifo_full  = (fcnt == 4'd8);

    always @(posedge clk) begin
        if (!rst_n || fifo_rst) begin
            fwp <= '0; frp <= '0; fcnt <= '0;
        end else if (fifo_we && fcnt < 4'd8) begin
            fmem[fwp] <= sw; fwp <= fwp + 3'd1; fcnt <= fcnt + 4'd1;
        end else if (fifo_re && fcnt != 4'd0) begin
            fifo_dout <= fmem[frp]; frp <= frp + 3'd1; fcnt <= fcnt - 4'd1;
        end else if (fifo_del && fcnt != 4'd0) begin
            fwp <= fwp - 3'd1; fcnt <= fcnt - 4'd1;
        end
    end

    // ---------------- behavioural sequencer model ----------------
    // Tracks "busy on a queue" plus a slot phase (fetch, load, dwell) and
    // the number of dwell cycles still owed for the current instruction.
    bit         m_busy = 0, m_paused = 0, m_clear = 0;
    int         m_phase = 0, m_left = 0;
    logic       m_we = 0, m_re = 0, m_del = 0, m_rst = 0, m_valid = 0, m_done = 0, m_err = 0;
    logic [1:0] m_dir = '0;
    logic [2:0] m_tq = '0;
    logic [4:0] m_steps = '0;

    always @(posedge clk) begin
        m_we = 0; m_re = 0; m_del = 0; m_rst = 0; m_done = 0; m_err = 0;
        if (!rst_n) begin
            m_busy = 0; m_paused = 0; m_clear = 0;
            m_valid = 0; m_dir = '0; m_tq = '0; m_steps = '0;
        end else if (m_clear) begin
            m_clear = 0;
        end else if (clear_pulse) begin
            m_clear = 1; m_busy = 0; m_paused = 0; m_rst = 1;
            m_valid = 0; m_dir = '0; m_tq = '0; m_steps = '0;
        end else if (!m_busy) begin
            if (execute_pulse) begin
                if (fifo_empty) m_err = 1;
                else begin m_busy = 1; m_phase = 0; m_re = 1; m_steps = '0; end
            end else if (save_pulse) begin
                if (fifo_full) m_err = 1; else m_we = 1;
            end else if (delete_pulse) begin
                m_del = 1;
            end
        end else if (m_paused) begin
            if (execute_pulse) begin m_paused = 0; m_valid = 1; end
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_tq = fifo_dout[4:2]; m_dir = fifo_dout[1:0]; m_valid = 1;
            if (m_steps != 5'd31) m_steps = m_steps + 5'd1;
            m_left = TICKS; m_phase = 2;
        end else if (execute_pulse) begin
            m_paused = 1; m_valid = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (fifo_empty) begin m_busy = 0; m_valid = 0; m_done = 1; end
                else begin m_phase = 0; m_re = 1; end
            end
        end
    end

    function automatic logic [2:0] m_state();
        if (m_clear) return 3'd5;
        if (!m_busy) return 3'd0;
        if (m_paused) return 3'd4;
        if (m_phase == 0) return 3'd1;
        if (m_phase == 1) return 3'd2;
        return 3'd3;
    endfunction

    logic [19:0] dut_vec, mod_vec;
    assign dut_vec = {fifo_we, fifo_re, fifo_del, fifo_rst, cmd_valid, cmd_dir, cmd_torque,
                      done, err, step_count, state_dbg};

    always @(negedge clk) begin
        mod_vec = {m_we, m_re, m_del, m_rst, m_valid, m_dir, m_tq, m_done, m_err, m_steps, m_state()};
        chk("cycle_vs_model", {12'b0, dut_vec}, {12'b0, mod_vec});
    end

    // ---------------- event monitors (sample end of each cycle) ----------------
    int re_cnt = 0, we_cnt = 0, del_cnt = 0, rst_cnt = 0, done_cnt = 0, err_cnt = 0;
    int valid_cnt = 0, pause_cyc = 0, pause_val = 0;
    logic [4:0] run_obs [$];

    always @(posedge clk) begin
        if (rst_n) begin
            re_cnt    += int'(fifo_re);
            we_cnt    += int'(fifo_we);
            del_cnt   += int'(fifo_del);
            rst_cnt   += int'(fifo_rst);
            done_cnt  += int'(done);
            err_cnt   += int'(err);
            valid_cnt += int'(cmd_valid);
            if (state_dbg == 3'd4) begin
                pause_cyc++;
                pause_val += int'(cmd_valid);
            end
            if (state_dbg == 3'd3) run_obs.push_back({cmd_dir, cmd_torque});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic c, input logic e, input logic s, input logic d);
        clear_pulse = c; execute_pulse = e; save_pulse = s; delete_pulse = d;
        @(negedge clk);
        clear_pulse = 0; execute_pulse = 0; save_pulse = 0; delete_pulse = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic save_word(input logic [4:0] w);
        sw = w;
        pulse(0, 0, 1, 0);
        idle(1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string nm);
        int n = 0;
        while (state_dbg !== s && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {29'b0, state_dbg}, {29'b0, s});
    endtask

    int b_re, b_we, b_del, b_rst, b_done, b_err, b_valid, b_pc, b_pv, ra;
    logic [4:0] exp_run [0:2];

    initial begin
        // Reset with all requests asserted.
        rst_n = 0;
        clear_pulse = 1; execute_pulse = 1; save_pulse = 1; delete_pulse = 1;
        idle(3);
        chk("reset_outputs", {12'b0, dut_vec}, 32'h0);
        clear_pulse = 0; execute_pulse = 0; save_pulse = 0; delete_pulse = 0;
        rst_n = 1;
        idle(2);

        // Basic run of three instructions.
        save_word(5'h05);
        save_word(5'h0E);
        save_word(5'h13);
        idle(1);
        b_re = re_cnt; b_done = done_cnt; b_valid = valid_cnt;
        run_obs.delete();
        pulse(0, 1, 0, 0);
        wait_state(3'd0, 100, "basic_return_idle");
        idle(2);
        chk("basic_re_pulses", re_cnt - b_re, 3);
        chk("basic_done_pulses", done_cnt - b_done, 1);
        chk("basic_step_count", {27'b0, step_count}, 3);
        chk("basic_valid_cycles", valid_cnt - b_valid, 16);
        chk("basic_run_cycles", run_obs.size(), 12);
        exp_run[0] = {DIR_REV,   3'd1};
        exp_run[1] = {DIR_LEFT,  3'd3};
        exp_run[2] = {DIR_RIGHT, 3'd4};
        for (int i = 0; i < 12; i++) begin
            if (i < run_obs.size()) chk("basic_cmd_seq", {27'b0, run_obs[i]}, {27'b0, exp_run[i / 4]});
        end

        // Execute with an empty queue.
        b_err = err_cnt; b_re = re_cnt;
        pulse(0, 1, 0, 0);
        idle(2);
        chk("empty_err", err_cnt - b_err, 1);
        chk("empty_no_re", re_cnt - b_re, 0);
        chk("empty_stay_idle", {29'b0, state_dbg}, 0);

        // Pause on the second dwell cycle, hold 10 cycles, resume.
        save_word(5'h05);
        save_word(5'h0E);
        pulse(0, 1, 0, 0);
        wait_state(3'd3, 20, "pause_reach_run");
        @(negedge clk);
        b_pc = pause_cyc; b_pv = pause_val;
        pulse(0, 1, 0, 0);
        chk("pause_entered", {29'b0, state_dbg}, 4);
        idle(9);
        pulse(0, 1, 0, 0);
        ra = 0;
        while (state_dbg == 3'd3 && ra < 20) begin
            ra++;
            @(negedge clk);
        end
        chk("resume_run_cycles", ra, 3);
        chk("resume_then_fetch", {29'b0, state_dbg}, 1);
        chk("pause_cycles", pause_cyc - b_pc, 10);
        chk("pause_valid_low", pause_val - b_pv, 0);
        wait_state(3'd0, 100, "pause_return_idle");
        chk("pause_step_count", {27'b0, step_count}, 2);

        // Abort mid-run; save+execute in the same cycle must be dropped.
        save_word(5'h05);
        save_word(5'h0E);
        pulse(0, 1, 0, 0);
        wait_state(3'd3, 20, "abort_reach_run");
        @(negedge clk);
        b_rst = rst_cnt; b_we = we_cnt;
        pulse(1, 1, 1, 0);
        chk("abort_state_clear", {29'b0, state_dbg}, 5);
        chk("abort_fifo_rst", {31'b0, fifo_rst}, 1);
        chk("abort_cmd_zero", {26'b0, cmd_valid, cmd_dir, cmd_torque}, 0);
        @(negedge clk);
        chk("abort_idle_next", {29'b0, state_dbg}, 0);
        chk("abort_fifo_flushed", {31'b0, fifo_empty}, 1);
        idle(2);
        chk("abort_rst_once", rst_cnt - b_rst, 1);
        chk("abort_save_dropped", we_cnt - b_we, 0);

        // Idle priority save over delete, then a plain delete.
        b_we = we_cnt; b_del = del_cnt;
        sw = 5'h1F;
        pulse(0, 0, 1, 1);
        idle(2);
        chk("prio_save_we", we_cnt - b_we, 1);
        chk("prio_delete_dropped", del_cnt - b_del, 0);
        pulse(0, 0, 0, 1);
        idle(2);
        chk("idle_delete", del_cnt - b_del, 1);
        chk("idle_delete_queue", {28'b0, fcnt}, 0);

        // Full queue and locked queue.
        for (int i = 0; i < 8; i++) save_word(5'(i + 1));
        idle(2);
        chk("queue_full", {31'b0, fifo_full}, 1);
        b_we = we_cnt; b_err = err_cnt;
        pulse(0, 0, 1, 0);
        idle(2);
        chk("full_no_we", we_cnt - b_we, 0);
        chk("full_err", err_cnt - b_err, 1);
        pulse(0, 1, 0, 0);
        wait_state(3'd3, 20, "locked_reach_run");
        b_we = we_cnt; b_del = del_cnt; b_err = err_cnt;
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        idle(2);
        chk("locked_no_we", we_cnt - b_we, 0);
        chk("locked_no_del", del_cnt - b_del, 0);
        chk("locked_no_err", err_cnt - b_err, 0);
        pulse(1, 0, 0, 0);
        wait_state(3'd0, 10, "locked_clear_idle");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Central controller for the instruction-queue robot datapath.
- Turns debounced key pulses into FIFO write/read/delete/reset strobes.
- Pops each queued 5-bit instruction and holds it as the active motor command for a fixed dwell period, with pause/resume and abort.
- Sits between the debouncers and the FIFO; its command outputs feed the torque, direction and speed displays.

Parameters:
- TICKS_PER_STEP, 50_000_000, dwell per instruction in clk cycles (1 s at 50 MHz); must be >= 2.
- STEP_W, 5, width of the executed-step counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous, active-low reset.
- save_pulse  in  1  one-cycle request: enqueue current switch word.
- execute_pulse  in  1  one-cycle request: start / pause / resume.
- clear_pulse  in  1  one-cycle request: flush queue, abort run.
- delete_pulse  in  1  one-cycle request: drop newest queue entry.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_dout  in  5  FIFO read data, valid the cycle after fifo_re: [4:2] torque, [1:0] direction.
- fifo_we  out  1  FIFO write strobe.
- fifo_re  out  1  FIFO read strobe.
- fifo_del  out  1  FIFO delete strobe.
- fifo_rst  out  1  FIFO flush strobe.
- cmd_valid  out  1  motor command active; gates the displays.
- cmd_dir  out  2  active direction.
- cmd_torque  out  3  active torque level.
- done  out  1  one-cycle pulse when the queue finishes executing.
- err  out  1  one-cycle pulse on a rejected save (full) or rejected execute (empty).
- step_count  out  STEP_W  instructions started since the last execute-from-IDLE; saturates at all-ones.
- state_dbg  out  3  encoded state for the LEDG lamps.

Behaviour:
- All outputs are registered.
- On reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - Every strobe, cmd_valid, done and err = 0.
  - cmd_dir, cmd_torque, step_count and the timer = 0.
  - Reset mid-run aborts immediately. It does not pulse fifo_rst; queue contents are the FIFO's own concern.
- States, in state_dbg encoding: IDLE=0, FETCH=1, LOAD=2, RUN=3, PAUSE=4, CLEAR=5.
- Input priority when several pulses coincide: clear > execute > save > delete. Only the highest is acted on; the others are dropped.
- IDLE:
  - save with fifo_full=0: fifo_we=1 for exactly the next cycle.
  - save with fifo_full=1: no fifo_we; err pulses.
  - delete: fifo_del=1 next cycle (underflow protection is the FIFO's job).
  - execute with fifo_empty=0: step_count cleared to 0, go to FETCH.
  - execute with fifo_empty=1: err pulses, stay IDLE.
  - clear: go to CLEAR.
- FETCH: fifo_re=1 for exactly one cycle, then LOAD.
- LOAD:
  - Capture fifo_dout into cmd_torque/cmd_dir.
  - cmd_valid=1; timer loaded with TICKS_PER_STEP-1.
  - step_count increments, saturating.
  - Then RUN.
- RUN:
  - Timer decrements once per cycle. Each instruction is held exactly TICKS_PER_STEP cycles of RUN.
  - Timer==0 and fifo_empty=0: go to FETCH. cmd_dir/cmd_torque/cmd_valid hold their previous values through FETCH and LOAD, so there is no display gap.
  - Timer==0 and fifo_empty=1: cmd_valid=0 and done=1 in the same next cycle; go to IDLE. cmd_dir/cmd_torque keep their last values.
  - execute: go to PAUSE; timer frozen; cmd_valid=0.
  - clear: go to CLEAR.
  - save and delete are ignored (queue locked), with no err.
- PAUSE:
  - execute: back to RUN; cmd_valid=1; timer resumes from its frozen value.
  - clear: go to CLEAR.
  - save and delete are ignored.
- CLEAR:
  - fifo_rst=1 for exactly one cycle.
  - cmd_valid=0; cmd_dir=0; cmd_torque=0; step_count=0.
  - Then IDLE.
- Timer width: $clog2(TICKS_PER_STEP). TICKS_PER_STEP is a compile-time constant, so there is no wrap-around risk.

Decomposition:
- Package seq_pkg holds:
  - seq_state_e enum with the encodings above.
  - instr_t packed struct {torque[2:0], dir[1:0]}.
  - Direction constants DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT.
- One sub-module, step_timer: loadable down-counter with load, enable (freeze when 0) and zero flag, parameterised by TICKS_PER_STEP. This module replaces the free-running countdown for sequencing.

Test Plan:
(All scenarios use TICKS_PER_STEP=4 and a behavioural 8-deep FIFO model.)
- Reset: hold rst_n=0 for 3 cycles with pulses active -> all outputs 0, state_dbg=0, no strobes.
- Basic run: save 5'h05, 5'h0E, 5'h13, then execute:
  - Three single-cycle fifo_re pulses.
  - cmd_dir/cmd_torque = 1/1, 2/3, 3/4, each held 4 RUN cycles.
  - cmd_valid continuous.
  - done pulses once; step_count=3; return to IDLE.
- Empty execute: execute with an empty queue -> err=1 for one cycle, no fifo_re, state stays IDLE.
- Pause/resume: execute at RUN timer=2 -> PAUSE, cmd_valid=0 for 10 cycles; execute again -> exactly 3 more RUN cycles before the next FETCH.
- Abort: clear mid-RUN -> fifo_rst high for exactly one cycle, cmd_valid and cmd fields 0, IDLE next cycle; save+execute issued in the same cycle as clear are ignored.
- Full/locked: save when fifo_full=1 -> no fifo_we, err pulse; save or delete during RUN -> no fifo_we/fifo_del, no err.
